text_char_server: RTL and testbench

TEXT_CHAR_SERVER -- requirements
Module: text_char_server

---
 rtl/text_char_pkg.sv | 41 ++++
 rtl/text_char_server_font_rom.sv | 54 +++++
 rtl/text_char_server.sv | 152 +++++++++++++++
 tb/tb_text_char_server.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/text_char_pkg.sv
// Shared types and constants for the text character server.
// FSM state enum, buffer geometry, blank code and "GAME OVER" string.
package text_char_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WRITE,
    ST_SHOW
  } state_e;

  localparam int         TEXT_CELLS = 256;
  localparam logic [6:0] CHAR_BLANK = 7'h20;
  localparam int         MSG_LEN    = 9;

  localparam logic [6:0] CH_G = 7'h47;
  localparam logic [6:0] CH_A = 7'h41;
  localparam logic [6:0] CH_M = 7'h4D;
  localparam logic [6:0] CH_E = 7'h45;
  localparam logic [6:0] CH_O = 7'h4F;
  localparam logic [6:0] CH_V = 7'h56;
  localparam logic [6:0] CH_R = 7'h52;

  function automatic logic [6:0] msg_char(input logic [3:0] idx);
    logic [6:0] c;
    c = CHAR_BLANK;
    case (idx)
      4'd0: c = CH_G;
      4'd1: c = CH_A;
      4'd2: c = CH_M;
      4'd3: c = CH_E;
      4'd5: c = CH_O;
      4'd6: c = CH_V;
      4'd7: c = CH_E;
      4'd8: c = CH_R;
      default: c = CHAR_BLANK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_char_server_font_rom.sv
// 8x16 glyph ROM: addr_i = {code[6:0], line[3:0]}, data_o registered (1 cycle).
// Ports: clk, rst (async high), addr_i[10:0], data_o[7:0] (MSB = leftmost pixel).
module font_rom
  import text_char_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);

  logic [6:0]  code;
  logic [3:0]  line;
  logic [63:0] glyph;
  logic [2:0]  row;
  logic [5:0]  base;
  logic [7:0]  data_d;
  logic [7:0]  data_q;

  assign code = addr_i[10:4];
  assign line = addr_i[3:0];

  // Glyphs occupy lines 4..11; top row is the high byte.
  always_comb begin
    glyph = '0;
    case (code)
      CH_G: glyph = 64'h3C66606E66663C00;
      CH_A: glyph = 64'h183C66667E666600;
      CH_M: glyph = 64'h63777F6B63636300;
      CH_E: glyph = 64'h7E60607C60607E00;
      CH_O: glyph = 64'h3C66666666663C00;
      CH_V: glyph = 64'h66666666663C1800;
      CH_R: glyph = 64'h7C66667C6C666300;
      default: glyph = '0;
    endcase
    row    = line[2:0] - 3'd4;
    base   = {3'd7 - row, 3'd0};
    data_d = '0;
    if (line[3:2] == 2'b01 || line[3:2] == 2'b10) begin
      data_d = glyph[base +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/text_char_server.sv
// Text-mode character server: 256-cell buffer, clear/message writer FSM,
// 2-stage pixel pipeline (buffer read, font read).
// Ports: clk, rst (async high), endgame, char_xy[7:0] {row,col},
//        char_line[3:0], frame_tick, char_pixel[7:0], busy.
// Optional macro TEXT_CHAR_BLINK_EN: blink the message in SHOW via frame_tick.
module text_char_server
  import text_char_pkg::*;
#(
  parameter int MSG_ROW = 7,
  parameter int MSG_COL = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       endgame,
  input  logic [7:0] char_xy,
  input  logic [3:0] char_line,
  input  logic       frame_tick,
  output logic [7:0] char_pixel,
  output logic       busy
);

  localparam logic [3:0] ROW       = 4'(MSG_ROW);
  localparam logic [3:0] COL       = 4'(MSG_COL);
  localparam logic [7:0] LAST_CELL = 8'(TEXT_CELLS - 1);
  localparam logic [7:0] LAST_CHAR = 8'(MSG_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       busy_q, busy_d;

  logic       we;
  logic [7:0] wa;
  logic [6:0] wd;

  logic [6:0] txt_mem [TEXT_CELLS];

  logic [6:0] code_q;
  logic [3:0] line_q;
  logic       kill1_q;
  logic       kill2_q;
  logic [7:0] glyph;
  logic       blank;

  // endgame is re-sampled at the end of each pass so the buffer
  // always converges to the current level.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we      = 1'b0;
    wa      = addr_q;
    wd      = CHAR_BLANK;
    unique case (state_q)
      ST_IDLE: begin
        if (endgame) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
        end
      end
      ST_CLEAR: begin
        we     = 1'b1;
        addr_d = addr_q + 8'd1;
        if (addr_q == LAST_CELL) begin
          state_d = endgame ? ST_WRITE : ST_IDLE;
        end
      end
      ST_WRITE: begin
        we     = 1'b1;
        wa     = {ROW, COL + addr_q[3:0]};
        wd     = msg_char(addr_q[3:0]);
        addr_d = addr_q + 8'd1;
        if (addr_q == LAST_CHAR) begin
          addr_d  = '0;
          state_d = endgame ? ST_SHOW : ST_CLEAR;
        end
      end
      ST_SHOW: begin
        if (!endgame) begin
          state_d = ST_CLEAR;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        addr_d  = '0;
      end
    endcase
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      addr_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      txt_mem[wa] <= wd;
    end
  end

  // Stage 1: buffer read; remember whether the read raced a rewrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      line_q  <= '0;
      kill1_q <= 1'b0;
      kill2_q <= 1'b0;
    end else begin
      code_q  <= txt_mem[char_xy];
      line_q  <= char_line;
      kill1_q <= busy_q;
      kill2_q <= kill1_q;
    end
  end

  // Stage 2: font lookup.
  font_rom u_font (
    .clk    (clk),
    .rst    (rst),
    .addr_i ({code_q, line_q}),
    .data_o (glyph)
  );

`ifdef TEXT_CHAR_BLINK_EN
  logic [5:0] frm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_q <= '0;
    end else if (frame_tick) begin
      frm_q <= frm_q + 6'd1;
    end
  end

  assign blank = frm_q[5] && (state_q == ST_SHOW);
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign blank = 1'b0;
`endif

  assign char_pixel = (kill2_q || blank) ? 8'h00 : glyph;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_char_server.sv
// Scoreboarded random bench for text_char_server.
// Reference model tracks buffer contents and rewrite passes abstractly.
module tb_text_char_server;

  localparam int ROW = 7;
  localparam int COL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       endgame = 1'b0;
  logic [7:0] char_xy = '0;
  logic [3:0] char_line = '0;
  logic       frame_tick = 1'b0;
  logic [7:0] char_pixel;
  logic       busy;

  text_char_server #(.MSG_ROW(ROW), .MSG_COL(COL)) dut (
    .clk        (clk),
    .rst        (rst),
    .endgame    (endgame),
    .char_xy    (char_xy),
    .char_line  (char_line),
    .frame_tick (frame_tick),
    .char_pixel (char_pixel),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference glyph rows (lines 4..11 of each 16-line cell).
  logic [7:0] FG [8] = '{8'h3C,8'h66,8'h60,8'h6E,8'h66,8'h66,8'h3C,8'h00};
  logic [7:0] FA [8] = '{8'h18,8'h3C,8'h66,8'h66,8'h7E,8'h66,8'h66,8'h00};
  logic [7:0] FM [8] = '{8'h63,8'h77,8'h7F,8'h6B,8'h63,8'h63,8'h63,8'h00};
  logic [7:0] FE [8] = '{8'h7E,8'h60,8'h60,8'h7C,8'h60,8'h60,8'h7E,8'h00};
  logic [7:0] FO [8] = '{8'h3C,8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h00};
  logic [7:0] FV [8] = '{8'h66,8'h66,8'h66,8'h66,8'h66,8'h3C,8'h18,8'h00};
  logic [7:0] FR [8] = '{8'h7C,8'h66,8'h66,8'h7C,8'h6C,8'h66,8'h63,8'h00};

  function automatic logic [7:0] ref_font(input logic [6:0] c, input int ln);
    int r;
    if (ln < 4 || ln > 11) return 8'h00;
    r = ln - 4;
    case (c)
      7'h47: return FG[r];
      7'h41: return FA[r];
      7'h4D: return FM[r];
      7'h45: return FE[r];
      7'h4F: return FO[r];
      7'h56: return FV[r];
      7'h52: return FR[r];
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    int         due;
    logic [7:0] exp;
    logic [7:0] xy;
    logic [3:0] ln;
  } sb_t;

  sb_t sb[$];

  // Model: buffer array plus a "rewrite pass" in progress.
  string      MSG = "GAME OVER";
  logic [6:0] m_buf [256];
  bit         m_busy = 1'b1;
  bit         m_content = 1'b0;
  int         m_phase = 0;
  logic [5:0] m_frm = '0;
  int         cyc = 0;

  initial for (int i = 0; i < 256; i++) m_buf[i] = 7'h20;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    = 1'b1;
      m_phase   = 0;
      m_content = 1'b0;
      m_frm     = '0;
      sb.delete();
    end else begin
      sb_t e;
      cyc++;
      e.due = cyc + 1;
      e.xy  = char_xy;
      e.ln  = char_line;
      e.exp = m_busy ? 8'h00 : ref_font(m_buf[char_xy], int'(char_line));
      sb.push_back(e);
      if (m_busy) begin
        if (m_phase < 256) begin
          m_buf[m_phase] = 7'h20;
          if (m_phase == 255) begin
            if (endgame) m_phase = 256;
            else begin m_busy = 0; m_content = 0; end
          end else m_phase++;
        end else begin
          int k;
          k = m_phase - 256;
          m_buf[ROW * 16 + (COL + k) % 16] = 7'(MSG[k]);
          if (k == 8) begin
            if (endgame) begin m_busy = 0; m_content = 1; end
            else m_phase = 0;
          end else m_phase++;
        end
      end else if (endgame != m_content) begin
        m_busy  = 1'b1;
        m_phase = 0;
      end
      if (frame_tick) m_frm = m_frm + 6'd1;
    end
  end

  // Monitor: busy every cycle, pixel whenever a request is due.
  always @(negedge clk) begin
    if (!rst) begin
      chk(busy == m_busy, "busy", int'(busy), int'(m_busy));
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        sb_t e;
        logic [7:0] want;
        e = sb.pop_front();
        want = e.exp;
`ifdef TEXT_CHAR_BLINK_EN
        if (m_frm[5] && !m_busy && m_content) want = 8'h00;
`endif
        if (e.due < cyc)
          chk(1'b0, "pix_late", e.due, cyc);
        else if (char_pixel != want)
          $display("FAIL pix xy=%h line=%0d got %h want %h",
                   e.xy, e.ln, char_pixel, want);
        n_chk++;
        if (e.due == cyc && char_pixel == want) n_pass++;
      end
    end
  end

  // Request driver: directed queue first, else random (row 7 biased).
  logic [11:0] dq[$];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (dq.size() > 0) begin
        {char_xy, char_line} = dq.pop_front();
      end else begin
        if ($urandom_range(1) == 1)
          char_xy = {4'(ROW), 4'($urandom_range(15))};
        else
          char_xy = 8'($urandom_range(255));
        char_line = 4'($urandom_range(15));
      end
      frame_tick = ($urandom_range(3) == 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure(input int exp_len, input string nm);
    int n = 0;
    int w = 0;
    @(negedge clk);
    while (!busy && w < 8) begin @(negedge clk); w++; end
    while (busy && n < 3000) begin n++; @(negedge clk); end
    chk(n == exp_len, nm, n, exp_len);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk(busy == 1'b1, "rst_busy", int'(busy), 1);
    chk(char_pixel == 8'h00, "rst_pix", int'(char_pixel), 0);
    step();
    rst = 1'b0;
    measure(256, "boot_clear");
    repeat (20) step();

    step();
    endgame = 1'b1;
    measure(265, "first_write");
    dq.push_back({8'h73, 4'd5});
    dq.push_back({8'h76, 4'd6});
    for (int i = 0; i < 9; i++)
      dq.push_back({8'(8'h73 + i), 4'(i)});
    for (int i = 0; i < 9; i++)
      dq.push_back({8'(8'h73 + i), 4'(i + 4)});
    repeat (60) step();

    endgame = 1'b0;
    measure(256, "show_clear");
    repeat (20) step();

    fork
      measure(256, "glitch50");
      begin
        step();
        endgame = 1'b1;
        repeat (50) step();
        endgame = 1'b0;
      end
    join
    repeat (20) step();

    fork
      measure(521, "late_drop");
      begin
        step();
        endgame = 1'b1;
        repeat (260) step();
        endgame = 1'b0;
      end
    join
    dq.push_back({8'h73, 4'd5});
    repeat (20) step();

    step();
    endgame = 1'b1;
    repeat (100) step();
    rst = 1'b1;
    @(negedge clk);
    chk(char_pixel == 8'h00, "midrst_pix", int'(char_pixel), 0);
    chk(busy == 1'b1, "midrst_busy", int'(busy), 1);
    step();
    step();
    rst = 1'b0;
    measure(265, "rst_restart");

    repeat (400) step();
    endgame = 1'b0;
    measure(256, "final_clear");
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
